// File: rtl/up_adc_capture_seq.sv
// Processor-clock sequencer for ADC capture DMA: ping-pong buffers with a 4-phase go/done handshake.
// Optional capture watchdog enabled by defining UP_ADC_SEQ_TIMEOUT_EN.
module up_adc_capture_seq #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TMO_WIDTH  = 24
) (
    input  logic                  up_clk,
    input  logic                  up_rstn,
    input  logic                  cfg_enable,
    input  logic                  cfg_continuous,
    input  logic [CNT_WIDTH-1:0]  cfg_num_captures,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_0,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_1,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [TMO_WIDTH-1:0]  cfg_timeout,
    input  logic                  done_in,
    input  logic                  overflow_in,
    input  logic                  irq_ack,
    input  logic                  err_clr,
    output logic                  go,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [LEN_WIDTH-1:0]  len,
    output logic                  buf_sel,
    output logic                  busy,
    output logic                  irq,
    output logic [CNT_WIDTH-1:0]  capture_count,
    output logic                  err_overflow,
    output logic                  err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_REQ   = 3'd2,
        S_ACK   = 3'd3,
        S_NEXT  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  en_prev_q;
    logic                  go_q, go_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  buf_sel_q, buf_sel_d;
    logic                  irq_q, irq_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic                  cont_q, cont_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  irq_set;
    logic                  ovf_set;
    logic                  tmo_set;

`ifdef UP_ADC_SEQ_TIMEOUT_EN
    logic [TMO_WIDTH-1:0]  wdog_q, wdog_d;
    logic [TMO_WIDTH-1:0]  wdog_inc;
    logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;
    logic                  err_tmo_q, err_tmo_d;
`else
    logic                  unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
`endif

    // Next-state, datapath and flag update
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        len_d     = len_q;
        buf_sel_d = buf_sel_q;
        count_d   = count_q;
        num_d     = num_q;
        cont_d    = cont_q;
        irq_set   = 1'b0;
        ovf_set   = 1'b0;
        tmo_set   = 1'b0;
`ifdef UP_ADC_SEQ_TIMEOUT_EN
        wdog_d    = wdog_q;
        tmo_d     = tmo_q;
        wdog_inc  = (wdog_q == {TMO_WIDTH{1'b1}}) ? wdog_q : wdog_q + TMO_WIDTH'(1);
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cfg_enable && !en_prev_q) begin
                    state_d   = S_ARM;
                    count_d   = '0;
                    buf_sel_d = 1'b0;
                end
            end
            S_ARM: begin
                wr_addr_d = buf_sel_q ? cfg_addr_1 : cfg_addr_0;
                len_d     = cfg_len;
                cont_d    = cfg_continuous;
                num_d     = (cfg_num_captures == '0) ? CNT_WIDTH'(1) : cfg_num_captures;
`ifdef UP_ADC_SEQ_TIMEOUT_EN
                tmo_d     = cfg_timeout;
                wdog_d    = '0;
`endif
                state_d   = cfg_enable ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                if (done_in) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!done_in) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                count_d   = count_q + CNT_WIDTH'(1);
                irq_set   = 1'b1;
                buf_sel_d = ~buf_sel_q;
                if (!cfg_enable) begin
                    state_d = S_IDLE;
                end else if (cont_q) begin
                    state_d = S_ARM;
                end else if (count_d >= num_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_ERROR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UP_ADC_SEQ_TIMEOUT_EN
        // Watchdog value counts the current cycle, so ERROR lands exactly cfg_timeout cycles after REQ entry
        if (state_q == S_REQ || state_q == S_ACK) begin
            wdog_d = wdog_inc;
            if (tmo_q != '0 && wdog_inc == tmo_q) begin
                tmo_set = 1'b1;
                state_d = S_ERROR;
            end
        end
`endif

        // Overflow aborts the capture: no count, no irq, no buffer toggle
        if (state_q != S_IDLE && state_q != S_ERROR && overflow_in) begin
            ovf_set   = 1'b1;
            state_d   = S_ERROR;
            irq_set   = 1'b0;
            count_d   = count_q;
            buf_sel_d = buf_sel_q;
        end

        irq_d     = irq_set ? 1'b1 : (irq_ack ? 1'b0 : irq_q);
        err_ovf_d = ovf_set ? 1'b1 : (err_clr ? 1'b0 : err_ovf_q);
`ifdef UP_ADC_SEQ_TIMEOUT_EN
        err_tmo_d = tmo_set ? 1'b1 : (err_clr ? 1'b0 : err_tmo_q);
`endif
        go_d      = (state_d == S_REQ);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state_q   <= S_IDLE;
            en_prev_q <= 1'b1;
            go_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= '0;
            len_q     <= '0;
            buf_sel_q <= 1'b0;
            irq_q     <= 1'b0;
            count_q   <= '0;
            num_q     <= CNT_WIDTH'(1);
            cont_q    <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= cfg_enable;
            go_q      <= go_d;
            busy_q    <= busy_d;
            wr_addr_q <= wr_addr_d;
            len_q     <= len_d;
            buf_sel_q <= buf_sel_d;
            irq_q     <= irq_d;
            count_q   <= count_d;
            num_q     <= num_d;
            cont_q    <= cont_d;
            err_ovf_q <= err_ovf_d;
        end
    end

`ifdef UP_ADC_SEQ_TIMEOUT_EN
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            wdog_q    <= '0;
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
        end
    end
    assign err_timeout = err_tmo_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign go            = go_q;
    assign wr_addr       = wr_addr_q;
    assign len           = len_q;
    assign buf_sel       = buf_sel_q;
    assign busy          = busy_q;
    assign irq           = irq_q;
    assign capture_count = count_q;
    assign err_overflow  = err_ovf_q;

endmodule

// File: tb/tb_up_adc_capture_seq.sv
// Directed self-checking bench for up_adc_capture_seq; a responder drives done_in by hand.
module tb_up_adc_capture_seq;

    logic        up_clk;
    logic        up_rstn;
    logic        cfg_enable;
    logic        cfg_continuous;
    logic [15:0] cfg_num_captures;
    logic [31:0] cfg_addr_0;
    logic [31:0] cfg_addr_1;
    logic [31:0] cfg_len;
    logic [23:0] cfg_timeout;
    logic        done_in;
    logic        overflow_in;
    logic        irq_ack;
    logic        err_clr;
    logic        go;
    logic [31:0] wr_addr;
    logic [31:0] len;
    logic        buf_sel;
    logic        busy;
    logic        irq;
    logic [15:0] capture_count;
    logic        err_overflow;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    up_adc_capture_seq dut (
        .up_clk           (up_clk),
        .up_rstn          (up_rstn),
        .cfg_enable       (cfg_enable),
        .cfg_continuous   (cfg_continuous),
        .cfg_num_captures (cfg_num_captures),
        .cfg_addr_0       (cfg_addr_0),
        .cfg_addr_1       (cfg_addr_1),
        .cfg_len          (cfg_len),
        .cfg_timeout      (cfg_timeout),
        .done_in          (done_in),
        .overflow_in      (overflow_in),
        .irq_ack          (irq_ack),
        .err_clr          (err_clr),
        .go               (go),
        .wr_addr          (wr_addr),
        .len              (len),
        .buf_sel          (buf_sel),
        .busy             (busy),
        .irq              (irq),
        .capture_count    (capture_count),
        .err_overflow     (err_overflow),
        .err_timeout      (err_timeout)
    );

    initial begin
        up_clk = 1'b0;
        forever #5 up_clk = ~up_clk;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge up_clk);
    endtask

    task automatic wait_go(output logic [31:0] a, output logic [31:0] l);
        int n = 0;
        while (go !== 1'b1 && n < 50) begin
            @(negedge up_clk);
            n++;
        end
        check("go_rise", 32'(go), 32'd1);
        a = wr_addr;
        l = len;
    endtask

    task automatic finish_hs(input int d_rise, input int d_fall);
        int n = 0;
        tick(d_rise);
        done_in = 1'b1;
        while (go !== 1'b0 && n < 50) begin
            @(negedge up_clk);
            n++;
        end
        check("go_drop", 32'(go), 32'd0);
        tick(d_fall);
        done_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge up_clk);
            n++;
        end
        check("idle", 32'(busy), 32'd0);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] a, l;
        int cnt;

        up_rstn          = 1'b0;
        cfg_enable       = 1'b1;
        cfg_continuous   = 1'b0;
        cfg_num_captures = 16'd1;
        cfg_addr_0       = 32'h1000_0000;
        cfg_addr_1       = 32'h2000_0000;
        cfg_len          = 32'h400;
        cfg_timeout      = 24'd0;
        done_in          = 1'b0;
        overflow_in      = 1'b0;
        irq_ack          = 1'b0;
        err_clr          = 1'b0;

        // Reset values
        tick(3);
        check("rst_go", 32'(go), 32'd0);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_len", len, 32'd0);
        check("rst_buf_sel", 32'(buf_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_count", 32'(capture_count), 32'd0);
        check("rst_err_ovf", 32'(err_overflow), 32'd0);
        check("rst_err_tmo", 32'(err_timeout), 32'd0);

        // Enable level held through reset must not start a run
        up_rstn = 1'b1;
        tick(5);
        check("held_level_busy", 32'(busy), 32'd0);
        check("held_level_go", 32'(go), 32'd0);
        cfg_enable = 1'b0;
        tick(2);

        // Single shot
        cfg_enable = 1'b1;
        wait_go(a, l);
        check("ss_wr_addr", a, 32'h1000_0000);
        check("ss_len", l, 32'h400);
        finish_hs(20, 5);
        wait_idle();
        check("ss_irq", 32'(irq), 32'd1);
        check("ss_count", 32'(capture_count), 32'd1);
        check("ss_buf_sel", 32'(buf_sel), 32'd1);
        pulse_ack();
        check("ss_irq_clr", 32'(irq), 32'd0);
        cfg_enable = 1'b0;
        tick(2);

        // Ping-pong over four captures
        cfg_num_captures = 16'd4;
        cfg_addr_0       = 32'h100;
        cfg_addr_1       = 32'h200;
        cfg_enable       = 1'b1;
        wait_go(a, l); check("pp_addr0", a, 32'h100); finish_hs(3, 2);
        wait_go(a, l); check("pp_addr1", a, 32'h200); finish_hs(1, 1);
        wait_go(a, l); check("pp_addr2", a, 32'h100); finish_hs(4, 3);
        wait_go(a, l); check("pp_addr3", a, 32'h200); finish_hs(2, 1);
        wait_idle();
        check("pp_count", 32'(capture_count), 32'd4);
        check("pp_buf_sel", 32'(buf_sel), 32'd0);
        tick(5);
        check("pp_no_restart", 32'(busy), 32'd0);
        cfg_enable = 1'b0;
        tick(2);

        // Continuous run stopped during REQ of capture 3
        cfg_continuous   = 1'b1;
        cfg_num_captures = 16'd2;
        cfg_enable       = 1'b1;
        wait_go(a, l); finish_hs(2, 2);
        wait_go(a, l); finish_hs(2, 2);
        wait_go(a, l);
        check("cont_addr3", a, 32'h100);
        cfg_enable = 1'b0;
        finish_hs(3, 2);
        wait_idle();
        check("cont_count", 32'(capture_count), 32'd3);
        check("cont_buf_sel", 32'(buf_sel), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge up_clk);
            if (go === 1'b1) cnt++;
        end
        check("cont_no_4th_go", 32'(cnt), 32'd0);
        cfg_continuous = 1'b0;

        // Overflow during REQ of capture 2
        cfg_num_captures = 16'd4;
        cfg_enable       = 1'b1;
        wait_go(a, l); finish_hs(2, 2);
        wait_go(a, l);
        overflow_in = 1'b1;
        tick(1);
        overflow_in = 1'b0;
        check("ovf_go", 32'(go), 32'd0);
        check("ovf_flag", 32'(err_overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_count", 32'(capture_count), 32'd1);
        check("ovf_buf_sel", 32'(buf_sel), 32'd1);
        tick(3);
        check("ovf_stays_error", 32'(busy), 32'd1);
        pulse_clr();
        check("ovf_clr_busy", 32'(busy), 32'd0);
        check("ovf_clr_flag", 32'(err_overflow), 32'd0);
        tick(3);
        check("ovf_no_restart", 32'(busy), 32'd0);

        // irq_ack coinciding with NEXT: set wins
        cfg_enable = 1'b0;
        pulse_ack();
        check("race_pre_irq", 32'(irq), 32'd0);
        cfg_num_captures = 16'd1;
        cfg_enable       = 1'b1;
        wait_go(a, l);
        finish_hs(3, 2);
        tick(1);
        check("race_irq_before_next", 32'(irq), 32'd0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("race_irq_set_wins", 32'(irq), 32'd1);
        wait_idle();
        pulse_ack();
        check("race_irq_later_clr", 32'(irq), 32'd0);
        cfg_enable = 1'b0;
        tick(2);

        // Watchdog: done never asserts
        cfg_timeout = 24'd100;
        cfg_enable  = 1'b1;
        wait_go(a, l);
        cnt = 1;
        while (go === 1'b1 && cnt < 300) begin
            @(negedge up_clk);
            if (go === 1'b1) cnt++;
        end
`ifdef UP_ADC_SEQ_TIMEOUT_EN
        check("tmo_req_cycles", 32'(cnt), 32'd100);
        check("tmo_flag", 32'(err_timeout), 32'd1);
        check("tmo_busy", 32'(busy), 32'd1);
        pulse_clr();
        check("tmo_clr_flag", 32'(err_timeout), 32'd0);
        check("tmo_clr_busy", 32'(busy), 32'd0);
`else
        check("tmo_go_held", 32'(cnt), 32'd300);
        check("tmo_go_still", 32'(go), 32'd1);
        check("tmo_flag_tied", 32'(err_timeout), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
